// File: rtl/icsp_loader.sv
// Bit-serial ICSP loader: decodes host commands on pgc/pgd and writes program memory.
// Build option: define ICSP_READ_EN to include the Read Data (6'h04) verify path.
module icsp_loader #(
    parameter int ADRS_W      = 9,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pgm_en,
    input  logic              pgc,
    input  logic              pgd_in,
    output logic              pgd_out,
    output logic              pgd_oe,
    output logic              cpu_hold,
    output logic              busy,
    output logic [ADRS_W-1:0] prog_adrs,
    output logic              prog_wr_en,
    output logic [DATA_W-1:0] prog_wr_data,
    input  logic [DATA_W-1:0] prog_rd_data
);

    typedef enum logic [2:0] {IDLE, CMD, LOAD, PROG, READ, ERASE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] pgm_en_sync, pgc_sync, pgd_sync;
    logic                   pgm_en_s, pgc_s, pgd_s;
    logic                   pgm_en_prev, pgc_prev;
    logic                   pgm_rise, pgc_rise, pulse, field_end;
    logic [3:0]             bit_cnt;
    logic [14:0]            sr;
    logic [15:0]            sr_next;
    logic [5:0]             cmd_code;
    logic [ADRS_W-1:0]      address, erase_cnt;
    logic [DATA_W-1:0]      latch;
    logic                   erase_last;
    logic                   unused_bits;

    assign pgm_en_s = pgm_en_sync[SYNC_STAGES-1];
    assign pgc_s    = pgc_sync[SYNC_STAGES-1];
    assign pgd_s    = pgd_sync[SYNC_STAGES-1];
    assign pgm_rise = pgm_en_s & ~pgm_en_prev;
    assign pgc_rise = pgc_s & ~pgc_prev;

    // pgc only matters in the shifting states, and never once the host has let go of pgm_en
    assign pulse      = pgc_rise && pgm_en_s && (state == CMD || state == LOAD || state == READ);
    assign field_end  = pulse && ((state == CMD) ? (bit_cnt == 4'd5) : (bit_cnt == 4'd15));
    assign sr_next    = {pgd_s, sr};
    assign cmd_code   = sr_next[15:10];
    assign erase_last = &erase_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pgm_en_sync <= '0;
            pgc_sync    <= '0;
            pgd_sync    <= '0;
            pgm_en_prev <= 1'b0;
            pgc_prev    <= 1'b0;
        end else begin
            pgm_en_sync <= {pgm_en_sync[SYNC_STAGES-2:0], pgm_en};
            pgc_sync    <= {pgc_sync[SYNC_STAGES-2:0], pgc};
            pgd_sync    <= {pgd_sync[SYNC_STAGES-2:0], pgd_in};
            pgm_en_prev <= pgm_en_s;
            pgc_prev    <= pgc_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!pgm_en_s) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (pgm_rise) state_next = CMD;
                CMD: begin
                    if (field_end) begin
                        case (cmd_code)
                            6'h02:   state_next = LOAD;
`ifdef ICSP_READ_EN
                            6'h04:   state_next = READ;
`endif
                            6'h08:   state_next = PROG;
                            6'h09:   state_next = ERASE;
                            default: state_next = CMD;
                        endcase
                    end
                end
                LOAD, READ: if (field_end) state_next = CMD;
                PROG:       state_next = CMD;
                ERASE:      if (erase_last) state_next = CMD;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt   <= '0;
            sr        <= '0;
            address   <= '0;
            latch     <= '1;
            erase_cnt <= '0;
        end else begin
            if (state_next != state || field_end) bit_cnt <= '0;
            else if (pulse)                       bit_cnt <= bit_cnt + 4'd1;

            if (pulse) sr <= sr_next[15:1];

            if (state == IDLE && state_next == CMD)
                address <= '0;
            else if (state == CMD && field_end && cmd_code == 6'h06)
                address <= address + 1'b1;

            // start bit is sr_next[0]; the data word sits just above it
            if (state == LOAD && field_end)
                latch <= sr_next[DATA_W:1];
            else if (state == ERASE && erase_last && pgm_en_s)
                latch <= '1;

            erase_cnt <= (state == ERASE) ? erase_cnt + 1'b1 : '0;
        end
    end

`ifdef ICSP_READ_EN
    logic [1:0]        rd_clk;
    logic [DATA_W-1:0] rd_data_q;
    logic [15:0]       rd_word;
    logic              pgd_out_q;

    assign rd_word = {{(15 - DATA_W){1'b0}}, rd_data_q, 1'b0};

    // ROM data follows prog_adrs by one clk, so it is taken on the second READ clk
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_clk    <= '0;
            rd_data_q <= '0;
            pgd_out_q <= 1'b0;
        end else begin
            if (state != READ)      rd_clk <= '0;
            else if (rd_clk != 2'd2) rd_clk <= rd_clk + 2'd1;

            if (state == READ && rd_clk == 2'd1) rd_data_q <= prog_rd_data;

            if (state != READ) pgd_out_q <= 1'b0;
            else if (pulse)    pgd_out_q <= rd_word[bit_cnt];
        end
    end

    assign pgd_out     = pgd_out_q;
    assign unused_bits = sr_next[0];
`else
    assign pgd_out     = 1'b0;
    assign unused_bits = ^{sr_next[0], prog_rd_data};
`endif

    always_comb begin
        cpu_hold     = (state != IDLE);
        busy         = (state == ERASE);
        prog_wr_en   = (state == PROG) || (state == ERASE);
        prog_adrs    = (state == ERASE) ? erase_cnt : address;
        prog_wr_data = (state == ERASE) ? '1 : latch;
`ifdef ICSP_READ_EN
        pgd_oe       = (state == READ);
`else
        pgd_oe       = 1'b0;
`endif
    end

endmodule
